tim_ctrl: RTL and testbench
===========================

# tim_ctrl

Timer control unit for the Timer_1 peripheral. It holds the prescaler and auto-reload preload/shadow registers and runs the synchronous prescaler tick. It also drives the 16-bit up/down main counter and generates update events (UEV), the update flag and the interrupt. It sits between the peripheral bus slave and the timer channels, which consume `cnt` and `tim_tick`.

## Interface
- `ARR_RST`, 16'hFFFF, reset value of ARR preload and shadow
- `PSC_RST`, 16'h0000, reset value of PSC preload and shadow
- `clk`  in  1  timer clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  register write strobe, one cycle per write
- `addr`  in  3  register select: 0 CR, 1 SR, 2 EGR, 3 PSC, 4 ARR, 5 CNT
- `wdata`  in  16  write data
- `rdata`  out  16  combinational read of `addr`; EGR reads 0; addr 6–7 read 0
- `cnt`  out  16  main counter value
- `tim_tick`  out  1  one-cycle prescaler tick (counter enable), never a gated clock
- `upd_evt`  out  1  one-cycle UEV pulse
- `irq`  out  1  UIF & UIE, level

## Operation
- CR bits: [0] CEN, [1] UDIS, [2] OPM, [3] ARPE, [4] DIR (0 = up, 1 = down), [5] UIE. Other bits read 0.
- SR[0] UIF: writing 0 clears it, writing 1 has no effect.
- EGR[0] UG: writing 1 requests a software UEV. It is self-clearing.
- PSC is always buffered: a write goes to the preload; the shadow loads only on UEV.
- ARR:
  - ARPE = 0: a write updates preload and shadow together.
  - ARPE = 1: the shadow loads on UEV.
- Prescaler (sub-module), while CEN = 1:
  - `tim_tick` = (psc_cnt == psc_shadow).
  - psc_cnt is cleared on tick, otherwise incremented.
  - While CEN = 0, psc_cnt holds and `tim_tick` = 0.
- Counter on tick:
  - Up: when cnt == arr_shadow, cnt goes to 0 (overflow); otherwise cnt + 1.
  - Down: when cnt == 0, cnt goes to arr_shadow (underflow); otherwise cnt − 1.
- UEV sources:
  - Overflow/underflow while UDIS = 0.
  - UG, always, regardless of UDIS.
- On UEV:
  - Load both shadows from the preloads.
  - Set UIF.
  - Pulse `upd_evt`.
- On UG, additionally:
  - Clear psc_cnt.
  - Set cnt to 0 (up) or to the new arr_shadow (down).
- OPM = 1: an overflow/underflow clears CEN in the same cycle, whether or not UDIS suppresses the UEV.
- CNT write loads cnt directly. A PSC write does not disturb psc_cnt.
- All arithmetic is modulo 2^16. ARR = 0 with up counting holds cnt at 0 and overflows on every tick.

## Timing
- Reset values:
  - CR = 0, UIF = 0, cnt = 0, psc_cnt = 0.
  - PSC preload/shadow = PSC_RST; ARR preload/shadow = ARR_RST.
  - `tim_tick`, `upd_evt`, `irq` = 0.
  - rdata follows addr.
- Reset has priority over everything, including mid-count.
- A write in cycle N is visible in registers at N+1.
- CEN written 1 in cycle N: the prescaler counts from N+1. With PSC = 0, `tim_tick` is high every cycle from N+1.
- Tick period is psc_shadow + 1 clocks. Counter period is (psc_shadow + 1)·(arr_shadow + 1) clocks.
- `tim_tick`, overflow detection and `upd_evt` are combinational on current state within the tick cycle. cnt, shadows and UIF update at the following edge. `irq` rises one cycle after `upd_evt`.
- Simultaneous events, in priority order:
  - rst
  - UG
  - CNT bus write over tick count update
  - UIF set over SR clear write
  - CEN clear by OPM over a same-cycle CR write setting CEN (the write is lost)
- PSC/ARR preload write in the same cycle as UEV: the shadow takes the new wdata.

## Structure
- Shared package `tim_pkg`:
  - register address constants TIM_CR, TIM_SR, TIM_EGR, TIM_PSC, TIM_ARR, TIM_CNT
  - CR bit index constants
  - counter width TIM_W = 16
- Sub-module `tim_psc_tick`: psc_cnt, comparator, `clr` input (UG), `en` input (CEN), `tick` output.
- Register file, counter and UEV logic stay in `tim_ctrl`.

## Test plan
- PSC = 3, ARR = 4, DIR = 0, CEN = 1:
  - `tim_tick` every 4 clocks; cnt 0,1,2,3,4,0.
  - `upd_evt` every 20 clocks; UIF = 1; with UIE = 1, `irq` = 1.
- ARPE = 1, ARR = 9 running, write ARR = 2 mid-period: cnt still reaches 9, then wraps 0..2.
- ARPE = 0: the same write takes effect immediately.
- DIR = 1, ARR = 3, PSC = 0: cnt 3,2,1,0,3 with UEV on each 0→3. OPM = 1 stops with CEN = 0, cnt = 3 after one underflow.
- UDIS = 1: overflow gives no `upd_evt` and UIF stays 0. UG write: `upd_evt`, cnt = 0, psc_cnt = 0, new PSC in shadow.
- SR write 0 in the same cycle as overflow UEV: UIF stays 1. CNT write 7 coincident with a tick: cnt = 7.
- rst asserted mid-count with PSC = 5, cnt = 3: next cycle all outputs at reset values. PSC shadow = PSC_RST, ARR shadow = ARR_RST.

Source files
------------

// File: rtl/tim_pkg.sv
// Shared constants for the Timer_1 control unit: register map, CR bit
// positions and counter width.
package tim_pkg;

   localparam int TIM_W   = 16;
   localparam int CR_BITS = 6;

   localparam logic [2:0] TIM_CR  = 3'd0;
   localparam logic [2:0] TIM_SR  = 3'd1;
   localparam logic [2:0] TIM_EGR = 3'd2;
   localparam logic [2:0] TIM_PSC = 3'd3;
   localparam logic [2:0] TIM_ARR = 3'd4;
   localparam logic [2:0] TIM_CNT = 3'd5;

   localparam int CR_CEN  = 0;
   localparam int CR_UDIS = 1;
   localparam int CR_OPM  = 2;
   localparam int CR_ARPE = 3;
   localparam int CR_DIR  = 4;
   localparam int CR_UIE  = 5;

   localparam logic [TIM_W-1:0] TIM_ONE = 16'd1;

endpackage

// File: rtl/tim_psc_tick.sv
// Synchronous prescaler: emits a one-cycle enable every psc+1 clocks while
// en is high. clr restarts the division (software update event).
module tim_psc_tick
   import tim_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [TIM_W-1:0] psc,
   output logic             tick
);

   logic [TIM_W-1:0] psc_cnt;

   assign tick = en && (psc_cnt == psc);

   always_ff @(posedge clk) begin
      if (rst) begin
         psc_cnt <= '0;
      end else if (clr) begin
         psc_cnt <= '0;
      end else if (en) begin
         psc_cnt <= tick ? '0 : psc_cnt + TIM_ONE;
      end
   end

endmodule

// File: rtl/tim_ctrl.sv
// Timer_1 control unit: register file, buffered PSC/ARR, up/down main
// counter, update-event generation, update flag and interrupt.
module tim_ctrl
   import tim_pkg::*;
#(
   parameter logic [TIM_W-1:0] ARR_RST = 16'hFFFF,
   parameter logic [TIM_W-1:0] PSC_RST = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [2:0]       addr,
   input  logic [TIM_W-1:0] wdata,
   output logic [TIM_W-1:0] rdata,
   output logic [TIM_W-1:0] cnt,
   output logic             tim_tick,
   output logic             upd_evt,
   output logic             irq
);

   logic [CR_BITS-1:0] cr;
   logic               uif;
   logic [TIM_W-1:0]   psc_pre, psc_sh, arr_pre, arr_sh, cnt_q;
   logic [TIM_W-1:0]   psc_new, arr_new;
   logic               wr_cr, wr_sr, wr_psc, wr_arr, wr_cnt;
   logic               ug, tick, wrap, uev;

   assign wr_cr  = wr_en && (addr == TIM_CR);
   assign wr_sr  = wr_en && (addr == TIM_SR);
   assign wr_psc = wr_en && (addr == TIM_PSC);
   assign wr_arr = wr_en && (addr == TIM_ARR);
   assign wr_cnt = wr_en && (addr == TIM_CNT);
   assign ug     = wr_en && (addr == TIM_EGR) && wdata[0];

   tim_psc_tick u_psc (
      .clk  (clk),
      .rst  (rst),
      .en   (cr[CR_CEN]),
      .clr  (ug),
      .psc  (psc_sh),
      .tick (tick)
   );

   // Wrap is detected even when UDIS masks the event, so OPM can still stop.
   assign wrap = tick && (cr[CR_DIR] ? (cnt_q == '0) : (cnt_q == arr_sh));
   assign uev  = ug || (wrap && !cr[CR_UDIS]);

   // A preload write coinciding with an update event lands in the shadow.
   assign psc_new = wr_psc ? wdata : psc_pre;
   assign arr_new = wr_arr ? wdata : arr_pre;

   always_ff @(posedge clk) begin
      if (rst) begin
         cr      <= '0;
         uif     <= 1'b0;
         psc_pre <= PSC_RST;
         psc_sh  <= PSC_RST;
         arr_pre <= ARR_RST;
         arr_sh  <= ARR_RST;
         cnt_q   <= '0;
      end else begin
         if (wr_cr) cr <= wdata[CR_BITS-1:0];
         if (wrap && cr[CR_OPM]) cr[CR_CEN] <= 1'b0;

         if (uev) uif <= 1'b1;
         else if (wr_sr && !wdata[0]) uif <= 1'b0;

         psc_pre <= psc_new;
         arr_pre <= arr_new;
         if (uev) begin
            psc_sh <= psc_new;
            arr_sh <= arr_new;
         end else if (wr_arr && !cr[CR_ARPE]) begin
            arr_sh <= wdata;
         end

         if (ug) cnt_q <= cr[CR_DIR] ? arr_new : '0;
         else if (wr_cnt) cnt_q <= wdata;
         else if (wrap) cnt_q <= cr[CR_DIR] ? arr_sh : '0;
         else if (tick) cnt_q <= cr[CR_DIR] ? cnt_q - TIM_ONE : cnt_q + TIM_ONE;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         TIM_CR:  rdata[CR_BITS-1:0] = cr;
         TIM_SR:  rdata[0] = uif;
         TIM_PSC: rdata = psc_pre;
         TIM_ARR: rdata = arr_pre;
         TIM_CNT: rdata = cnt_q;
         default: rdata = '0;
      endcase
   end

   assign cnt      = cnt_q;
   assign tim_tick = tick;
   assign upd_evt  = uev;
   assign irq      = uif && cr[CR_UIE];

endmodule

// File: tb/tb_tim_ctrl.sv
// Bench for tim_ctrl: register-level vector table, directed multi-cycle
// scenarios and random traffic, all checked against a behavioural model.
module tb_tim_ctrl;
   import tim_pkg::*;

   logic        clk = 1'b0;
   logic        rst, wr_en;
   logic [2:0]  addr;
   logic [15:0] wdata, rdata, cnt;
   logic        tim_tick, upd_evt, irq;

   int errors = 0;
   int checks = 0;
   logic [34:0] exp_q[$];
   logic [34:0] s_out;
   logic [15:0] s_rd, s_cnt;
   logic        s_tick, s_upd, s_irq;

   assign s_rd   = s_out[34:19];
   assign s_cnt  = s_out[18:3];
   assign s_tick = s_out[2];
   assign s_upd  = s_out[1];
   assign s_irq  = s_out[0];

   // reference model state
   logic [5:0] m_cr;
   bit         m_uif;
   int         m_cnt, m_pc, m_psc_pre, m_psc_sh, m_arr_pre, m_arr_sh;

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rd;
      logic [15:0] cnt;
      logic        tick;
      logic        upd;
      logic        irq;
   } vec_t;
   vec_t vecs[22];

   tim_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .cnt      (cnt),
      .tim_tick (tim_tick),
      .upd_evt  (upd_evt),
      .irq      (irq)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_cr = '0; m_uif = 0; m_cnt = 0; m_pc = 0;
      m_psc_pre = 0; m_psc_sh = 0; m_arr_pre = 65535; m_arr_sh = 65535;
   endfunction

   // Outputs from the present state and inputs, then advance one clock.
   task automatic model_step(output logic [34:0] e);
      bit tick, wrap, ug, upd;
      int rd, psc_in, arr_in;
      logic [5:0] c;
      c    = m_cr;
      tick = c[CR_CEN] && (m_pc == m_psc_sh);
      wrap = tick && (c[CR_DIR] ? (m_cnt == 0) : (m_cnt == m_arr_sh));
      ug   = wr_en && (addr == TIM_EGR) && wdata[0];
      upd  = ug || (wrap && !c[CR_UDIS]);
      case (addr)
         TIM_CR:  rd = int'(c);
         TIM_SR:  rd = int'(m_uif);
         TIM_PSC: rd = m_psc_pre;
         TIM_ARR: rd = m_arr_pre;
         TIM_CNT: rd = m_cnt;
         default: rd = 0;
      endcase
      e = {rd[15:0], m_cnt[15:0], tick, upd, m_uif && c[CR_UIE]};
      if (rst) begin
         model_reset();
         return;
      end
      psc_in = (wr_en && addr == TIM_PSC) ? int'(wdata) : m_psc_pre;
      arr_in = (wr_en && addr == TIM_ARR) ? int'(wdata) : m_arr_pre;
      if (ug) m_cnt = c[CR_DIR] ? arr_in : 0;
      else if (wr_en && addr == TIM_CNT) m_cnt = int'(wdata);
      else if (wrap) m_cnt = c[CR_DIR] ? m_arr_sh : 0;
      else if (tick) m_cnt = (m_cnt + (c[CR_DIR] ? 65535 : 1)) % 65536;
      if (ug || tick) m_pc = 0;
      else if (c[CR_CEN]) m_pc = m_pc + 1;
      if (wr_en && addr == TIM_CR) m_cr = wdata[5:0];
      if (wrap && c[CR_OPM]) m_cr[CR_CEN] = 1'b0;
      if (upd) m_uif = 1;
      else if (wr_en && addr == TIM_SR && !wdata[0]) m_uif = 0;
      if (upd) begin
         m_psc_sh = psc_in;
         m_arr_sh = arr_in;
      end else if (wr_en && addr == TIM_ARR && !c[CR_ARPE]) begin
         m_arr_sh = arr_in;
      end
      m_psc_pre = psc_in;
      m_arr_pre = arr_in;
   endtask

   // driver: one clock per call, outputs scored at the falling edge
   task automatic drive(input logic w, input logic [2:0] a, input logic [15:0] d);
      logic [34:0] e;
      wr_en = w; addr = a; wdata = d;
      @(negedge clk);
      model_step(e);
      exp_q.push_back(e);
      s_out = {rdata, cnt, tim_tick, upd_evt, irq};
      check("cycle", s_out, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
      drive(1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, TIM_CNT, 16'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, TIM_CNT, 16'h0);
      rst = 1'b0;
   endtask

   task automatic set_vec(input int i, input logic w, input logic [2:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input logic [15:0] c,
                          input logic t, input logic u, input logic q);
      vecs[i] = '{w, a, d, rd, c, t, u, q};
   endtask

   task automatic arpe_run(input bit arpe);
      bit seen9, wrapped;
      int maxafter;
      do_reset();
      write_reg(TIM_ARR, 16'd9);
      write_reg(TIM_CR, arpe ? 16'h09 : 16'h01);
      idle(1);
      write_reg(TIM_ARR, 16'd2);
      seen9 = 0; wrapped = 0; maxafter = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (s_cnt == 16'd9) seen9 = 1;
         if (s_cnt == 16'd0) wrapped = 1;
         if (wrapped && int'(s_cnt) > maxafter) maxafter = int'(s_cnt);
      end
      check(arpe ? "arpe1_reach9" : "arpe0_reach9", seen9, arpe);
      check(arpe ? "arpe1_newmax" : "arpe0_newmax", maxafter, 2);
   endtask

   initial begin
      int last_tick, last_upd, nt, nu, first;
      bit found;
      logic [2:0] a;
      logic [15:0] d;

      rst = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // register-level vector table, starting from reset
      set_vec( 0, 0, TIM_CR,  16'h0,  16'h0,    16'd0, 0, 0, 0);
      set_vec( 1, 0, TIM_ARR, 16'h0,  16'hFFFF, 16'd0, 0, 0, 0);
      set_vec( 2, 1, TIM_PSC, 16'h1,  16'h0,    16'd0, 0, 0, 0);
      set_vec( 3, 1, TIM_ARR, 16'h2,  16'hFFFF, 16'd0, 0, 0, 0);
      set_vec( 4, 1, TIM_CR,  16'h21, 16'h0,    16'd0, 0, 0, 0);
      set_vec( 5, 0, TIM_CNT, 16'h0,  16'h0,    16'd0, 1, 0, 0);
      set_vec( 6, 0, TIM_CNT, 16'h0,  16'h1,    16'd1, 1, 0, 0);
      set_vec( 7, 0, TIM_CNT, 16'h0,  16'h2,    16'd2, 1, 1, 0);
      set_vec( 8, 0, TIM_CNT, 16'h0,  16'h0,    16'd0, 0, 0, 1);
      set_vec( 9, 0, TIM_CNT, 16'h0,  16'h0,    16'd0, 1, 0, 1);
      set_vec(10, 0, TIM_CNT, 16'h0,  16'h1,    16'd1, 0, 0, 1);
      set_vec(11, 0, TIM_CNT, 16'h0,  16'h1,    16'd1, 1, 0, 1);
      set_vec(12, 0, TIM_SR,  16'h0,  16'h1,    16'd2, 0, 0, 1);
      set_vec(13, 1, TIM_SR,  16'h0,  16'h1,    16'd2, 1, 1, 1);
      set_vec(14, 0, TIM_SR,  16'h0,  16'h1,    16'd0, 0, 0, 1);
      set_vec(15, 1, TIM_SR,  16'h0,  16'h1,    16'd0, 1, 0, 1);
      set_vec(16, 0, TIM_SR,  16'h0,  16'h0,    16'd1, 0, 0, 0);
      set_vec(17, 1, TIM_CNT, 16'h7,  16'h1,    16'd1, 1, 0, 0);
      set_vec(18, 0, TIM_CNT, 16'h0,  16'h7,    16'd7, 0, 0, 0);
      set_vec(19, 0, TIM_CNT, 16'h0,  16'h7,    16'd7, 1, 0, 0);
      set_vec(20, 1, TIM_EGR, 16'h1,  16'h0,    16'd8, 0, 1, 0);
      set_vec(21, 0, TIM_CNT, 16'h0,  16'h0,    16'd0, 0, 0, 1);
      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d", i), s_out,
               {vecs[i].rd, vecs[i].cnt, vecs[i].tick, vecs[i].upd, vecs[i].irq});
      end

      // PSC=3, ARR=4 up counting: tick every 4, UEV every 20
      do_reset();
      write_reg(TIM_PSC, 16'd3);
      write_reg(TIM_ARR, 16'd4);
      write_reg(TIM_EGR, 16'd1);
      write_reg(TIM_SR, 16'd0);
      write_reg(TIM_CR, 16'h21);
      last_tick = -1; last_upd = -1; nt = 0; nu = 0;
      for (int i = 0; i < 64; i++) begin
         idle(1);
         if (s_tick) begin
            if (last_tick >= 0) check("tick_period", i - last_tick, 4);
            check("cnt_at_tick", s_cnt, nt % 5);
            nt++;
            last_tick = i;
         end
         if (s_upd) begin
            if (last_upd >= 0) check("uev_period", i - last_upd, 20);
            last_upd = i;
            nu++;
         end
      end
      check("uev_count", nu, 3);
      check("irq_level", s_irq, 1);

      arpe_run(1'b1);
      arpe_run(1'b0);

      // down counting, then one-pulse stop
      do_reset();
      write_reg(TIM_ARR, 16'd3);
      write_reg(TIM_CR, 16'h10);
      write_reg(TIM_EGR, 16'd1);
      write_reg(TIM_CR, 16'h11);
      for (int i = 0; i < 8; i++) begin
         idle(1);
         check("down_cnt", s_cnt, 3 - (i % 4));
         check("down_uev", s_upd, (i % 4) == 3);
      end
      write_reg(TIM_CR, 16'h15);
      idle(8);
      drive(1'b0, TIM_CR, 16'h0);
      check("opm_cen", s_rd[CR_CEN], 0);
      check("opm_cnt", s_cnt, 3);

      // UDIS masks overflow events; UG still fires and reloads PSC
      do_reset();
      write_reg(TIM_ARR, 16'd2);
      write_reg(TIM_CR, 16'h03);
      nu = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         nu += int'(s_upd);
      end
      check("udis_no_uev", nu, 0);
      drive(1'b0, TIM_SR, 16'h0);
      check("udis_uif", s_rd, 0);
      write_reg(TIM_PSC, 16'd5);
      write_reg(TIM_EGR, 16'd1);
      check("ug_uev", s_upd, 1);
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         idle(1);
         if (k == 1) check("ug_cnt", s_cnt, 0);
         if (s_tick && first < 0) first = k;
      end
      check("ug_psc_shadow", first, 6);

      // reset in the middle of a count
      do_reset();
      write_reg(TIM_PSC, 16'd5);
      write_reg(TIM_EGR, 16'd1);
      write_reg(TIM_CR, 16'h01);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         idle(1);
         if (s_cnt == 16'd3) found = 1;
      end
      check("reach_cnt3", found, 1);
      do_reset();
      drive(1'b0, TIM_PSC, 16'h0);
      check("rst_outputs", {s_cnt, s_tick, s_upd, s_irq}, 0);
      check("rst_psc_pre", s_rd, 0);
      drive(1'b0, TIM_ARR, 16'h0);
      check("rst_arr_pre", s_rd, 16'hFFFF);
      write_reg(TIM_CR, 16'h01);
      nt = 0;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         nt += int'(s_tick);
      end
      check("rst_psc_shadow", nt, 5);
      check("rst_arr_shadow", s_cnt, 4);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 99) < 75) begin
            drive(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));
         end else begin
            a = 3'($urandom_range(0, 5));
            case (a)
               TIM_CR:  d = 16'($urandom_range(0, 63)) | (($urandom_range(0, 9) < 8) ? 16'd1 : 16'd0);
               TIM_PSC: d = 16'($urandom_range(0, 3));
               TIM_ARR: d = 16'($urandom_range(0, 7));
               TIM_CNT: d = 16'($urandom_range(0, 7));
               default: d = 16'($urandom_range(0, 1));
            endcase
            write_reg(a, d);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
